conv_mac_acc: RTL and testbench
===============================

# conv_mac_acc

Parametrised successor to the fixed 3x3 convolution MAC in the CNN datapath. It convolves a KSIZE x KSIZE window of unsigned pixels with signed fixed-point coefficients that are loaded at runtime rather than hard-coded. Windows for the same output pixel arrive one input channel after another; the block accumulates them across NUM_CH channels, then adds bias, applies optional ReLU and saturates the result. It sits between the line-buffer/window generator and the pooling/activation stage.

## Interface
- KSIZE, 3, kernel edge; TAPS = KSIZE*KSIZE
- PIX_W, 8, unsigned pixel width
- COEF_W, 16, signed coefficient/bias width, Q2.13 (1 sign, 2 int, 13 frac)
- ACC_W, 24, signed output width, same 13 fraction bits
- NUM_CH, 1, input channels accumulated per output
- RELU, 0, 1 = clamp negative results to 0
- CADDR_W, $clog2(TAPS*NUM_CH+1), coefficient address width (derived)

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_pixel_data  in  TAPS*PIX_W  window; tap t = bits [t*PIX_W +: PIX_W]
- i_pixel_data_valid  in  1  window valid, one per cycle max
- i_coef_wr_en  in  1  coefficient write strobe
- i_coef_wr_addr  in  CADDR_W  ch*TAPS+tap; address TAPS*NUM_CH = bias
- i_coef_wr_data  in  COEF_W  coefficient/bias value
- o_convolved_data  out  ACC_W  saturated result
- o_convolved_data_valid  out  1  result valid, 1-cycle pulse per output

## Operation
- Coefficient RAM: TAPS*NUM_CH entries plus bias, all reset to 0. A write takes effect at the next edge. Out-of-range addresses are ignored. Coefficients are read at the multiply stage, so a write affects windows sampled after the write edge.
- Channel counter ch_cnt (0..NUM_CH-1), reset 0. Increments on each accepted window and wraps from NUM_CH-1 to 0. Holds while valid is low, so gaps are allowed anywhere. The window with ch_cnt==NUM_CH-1 is tagged last.
- Stage 1: TAPS products, each signed(coef) * signed({1'b0,pix}), width COEF_W+PIX_W+1. The ch/last tag is registered alongside.
- Stage 2: KSIZE row sums, registered.
- Stage 3: window sum, registered.
- Internal width is full precision: product width + $clog2(TAPS*NUM_CH) + 2 guard bits. No intermediate overflow.
- Stage 4 accumulator:
  - Non-last window: acc <= (ch==0 ? win : acc+win).
  - Last window: r = acc_in + win + sext(bias), where acc_in = 0 if NUM_CH==1.
  - If RELU and r<0, r = 0.
  - Output <= r saturated to signed ACC_W (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
  - acc cleared; valid pulses.
- The bias shares the 13-bit fraction of the products, so no shift is applied; it is sign-extended only.

## Timing
- Fully pipelined: one window per cycle sustained, no backpressure.
- Latency: last-channel window sampled at edge N gives output and valid registered at edge N+3, visible the following cycle (4 register stages).
- o_convolved_data holds its value between valid pulses. o_convolved_data_valid is high exactly one cycle per NUM_CH accepted windows.
- Reset (synchronous, active-high), at the next edge:
  - o_convolved_data = 0, o_convolved_data_valid = 0.
  - ch_cnt, acc, all stage valids/tags cleared; coefficients and bias = 0.
- Reset mid-operation: in-flight windows and partial accumulations are discarded, with no output for them. The first window after deassertion is channel 0.
- Simultaneous coefficient write and window at the same edge: the window uses the old coefficient.
- Valid low at a stage: that stage's data registers may update, but acc must not change and no output pulse is produced.

## Test plan
- NUM_CH=1, all coefs 0x2000 (1.0), bias 0, all pixels 10, one window → one valid pulse 4 cycles later, data 0x0B4000 (737280).
- NUM_CH=1, coefs 0x7FFF, pixels 255 → 0x7FFFFF (positive saturation). Coefs 0x8000 → 0x800000; rebuild with RELU=1 → 0x000000.
- NUM_CH=2, ch0 coefs 0x2000 / pixels 1, ch1 coefs 0x2000 / pixels 2, bias 0x2000 → single pulse after the ch1 window, data 0x038000. No pulse after ch0.
- NUM_CH=2, 100 back-to-back windows with random idle gaps inserted → exactly 50 pulses, each matching the reference model. Counter holds across gaps.
- Reset for 1 cycle between a ch0 and a ch1 window, then a fresh ch0/ch1 pair → only the post-reset pair produces output, and it equals the fresh-pair result.
- Write tap 4 of ch0 at the same edge as a window → that window uses the old value; the next window uses the new value. Write to address TAPS*NUM_CH+1 → no coefficient change.

Source files
------------

// File: rtl/conv_mac_acc.sv
// Runtime-loadable KSIZE x KSIZE convolution MAC, accumulated over NUM_CH input
// channels, with bias, optional ReLU and output saturation. Four register stages.
module conv_mac_acc #(
  parameter int KSIZE  = 3,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 24,
  parameter int NUM_CH = 1,
  parameter int RELU   = 0,
  localparam int TAPS    = KSIZE * KSIZE,
  localparam int CADDR_W = $clog2(TAPS * NUM_CH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [TAPS*PIX_W-1:0] i_pixel_data,
  input  logic                  i_pixel_data_valid,
  input  logic                  i_coef_wr_en,
  input  logic [CADDR_W-1:0]    i_coef_wr_addr,
  input  logic [COEF_W-1:0]     i_coef_wr_data,
  output logic [ACC_W-1:0]      o_convolved_data,
  output logic                  o_convolved_data_valid
);

  localparam int NCOEF  = TAPS * NUM_CH;
  localparam int PROD_W = COEF_W + PIX_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(TAPS * NUM_CH) + 2;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // The bias lives in the top entry, directly above the last channel's taps.
  logic signed [COEF_W-1:0] coef [NCOEF+1];
  logic [CH_W-1:0]          ch_cnt;

  logic signed [PROD_W-1:0] prod_next [TAPS];
  logic signed [PROD_W-1:0] prod [TAPS];
  logic                     s1_valid, s1_first, s1_last;
  logic signed [SUM_W-1:0]  row_next [KSIZE];
  logic signed [SUM_W-1:0]  row [KSIZE];
  logic                     s2_valid, s2_first, s2_last;
  logic signed [SUM_W-1:0]  win_next;
  logic signed [SUM_W-1:0]  win;
  logic                     s3_valid, s3_first, s3_last;
  logic signed [SUM_W-1:0]  acc;
  logic signed [SUM_W-1:0]  acc_in;
  logic signed [SUM_W-1:0]  res;
  logic signed [SUM_W-1:0]  res_relu;
  logic [ACC_W-1:0]         out_data;
  logic                     out_valid;

  function automatic logic [CADDR_W-1:0] coef_idx(input logic [CH_W-1:0] ch, input int t);
    return CADDR_W'(ch) * CADDR_W'(TAPS) + CADDR_W'(t);
  endfunction

  function automatic logic [ACC_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v > OUT_MAX) begin
      return OUT_MAX[ACC_W-1:0];
    end else if (v < OUT_MIN) begin
      return OUT_MIN[ACC_W-1:0];
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

  // Coefficient/bias store; out-of-range addresses are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int a = 0; a <= NCOEF; a++) coef[a] <= '0;
    end else if (i_coef_wr_en && (i_coef_wr_addr <= CADDR_W'(NCOEF))) begin
      coef[i_coef_wr_addr] <= i_coef_wr_data;
    end
  end

  // Channel counter advances only on accepted windows.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ch_cnt <= '0;
    end else if (i_pixel_data_valid) begin
      ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CH_W'(1);
    end
  end

  // Stage 1 multipliers: pixels are zero-extended into a signed operand.
  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      prod_next[t] = PROD_W'(coef[coef_idx(ch_cnt, t)])
                   * PROD_W'($signed({1'b0, i_pixel_data[t*PIX_W +: PIX_W]}));
    end
  end

  // Stage 1 registers; data may update freely, only valid/tags gate the accumulator.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= i_pixel_data_valid;
      s1_first <= (ch_cnt == '0);
      s1_last  <= (ch_cnt == LAST_CH);
    end
    prod <= prod_next;
  end

  // Stage 2 row sums.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      row_next[r] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        row_next[r] = row_next[r] + SUM_W'(prod[r*KSIZE + c]);
      end
    end
  end

  // Stage 2 registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
    row <= row_next;
  end

  // Stage 3 window sum.
  always_comb begin
    win_next = '0;
    for (int r = 0; r < KSIZE; r++) begin
      win_next = win_next + row[r];
    end
  end

  // Stage 3 registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
    end else begin
      s3_valid <= s2_valid;
      s3_first <= s2_first;
      s3_last  <= s2_last;
    end
    win <= win_next;
  end

  // Final result: bias shares the product fraction, so it is only sign-extended.
  always_comb begin
    acc_in = s3_first ? '0 : acc;
    res    = acc_in + win + SUM_W'(coef[NCOEF]);
    if ((RELU != 0) && res[SUM_W-1]) begin
      res_relu = '0;
    end else begin
      res_relu = res;
    end
  end

  // Stage 4 accumulator and output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (s3_valid) begin
        if (s3_last) begin
          acc       <= '0;
          out_data  <= saturate(res_relu);
          out_valid <= 1'b1;
        end else begin
          acc <= s3_first ? win : acc + win;
        end
      end
    end
  end

  assign o_convolved_data       = out_data;
  assign o_convolved_data_valid = out_valid;

endmodule

// File: tb/tb_conv_mac_acc.sv
// Directed bench for conv_mac_acc: single-channel table, ReLU variant and a
// two-channel instance for accumulation, gap, reset and write-collision sequences.
module tb_conv_mac_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] pix;
  logic [15:0] wdata;
  logic        v1, v2, v3, we1, we2;
  logic [3:0]  wa1;
  logic [4:0]  wa2;
  logic [23:0] d1, d2, d3;
  logic        ov1, ov2, ov3;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] q1[$];
  logic [23:0] q2[$];
  logic [23:0] expq[$];
  logic signed [15:0] c2 [19];

  always #5 clk = ~clk;

  conv_mac_acc #(.NUM_CH(1), .RELU(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(v1),
    .i_coef_wr_en(we1), .i_coef_wr_addr(wa1), .i_coef_wr_data(wdata),
    .o_convolved_data(d1), .o_convolved_data_valid(ov1));

  conv_mac_acc #(.NUM_CH(2), .RELU(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(v2),
    .i_coef_wr_en(we2), .i_coef_wr_addr(wa2), .i_coef_wr_data(wdata),
    .o_convolved_data(d2), .o_convolved_data_valid(ov2));

  conv_mac_acc #(.NUM_CH(1), .RELU(1)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(v3),
    .i_coef_wr_en(we1), .i_coef_wr_addr(wa1), .i_coef_wr_data(wdata),
    .o_convolved_data(d3), .o_convolved_data_valid(ov3));

  always @(negedge clk) begin
    if (ov1) q1.push_back(d1);
    if (ov2) q2.push_back(d2);
  end

  typedef struct packed {
    logic        dsel;   // 0: plain instance, 1: ReLU instance
    logic [15:0] c;
    logic [15:0] b;
    logic [7:0]  p;
    logic [23:0] e;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr1(input int a, input logic [15:0] d);
    we1 = 1'b1; wa1 = a[3:0]; wdata = d;
    tick();
    we1 = 1'b0;
  endtask

  task automatic wr2(input int a, input logic [15:0] d);
    we2 = 1'b1; wa2 = a[4:0]; wdata = d;
    tick();
    we2 = 1'b0;
  endtask

  task automatic load1(input logic [15:0] c, input logic [15:0] b);
    for (int a = 0; a < 9; a++) wr1(a, c);
    wr1(9, b);
  endtask

  task automatic load2();
    for (int a = 0; a < 19; a++) wr2(a, c2[a]);
  endtask

  function automatic longint dot(input int ch, input logic [71:0] pv);
    longint s = 0;
    for (int t = 0; t < 9; t++) begin
      longint cc = c2[ch*9 + t];
      s += cc * longint'(pv[t*8 +: 8]);
    end
    return s;
  endfunction

  function automatic logic [23:0] sat24(input longint r);
    if (r > 64'sd8388607) return 24'h7FFFFF;
    else if (r < -64'sd8388608) return 24'h800000;
    else return r[23:0];
  endfunction

  function automatic logic [23:0] qat(input int which, input int i);
    if (which == 1) return (i < q1.size()) ? q1[i] : 24'hFFFFFF;
    else return (i < q2.size()) ? q2[i] : 24'hFFFFFF;
  endfunction

  initial begin
    vec_t vt[16];
    logic [95:0] rnd;
    logic [71:0] pv;
    longint partial;
    logic [23:0] e;
    logic sel_v;
    logic [23:0] sel_d;

    vt[0]  = '{1'b0, 16'h2000, 16'h0000, 8'd10,  24'h0B4000};
    vt[1]  = '{1'b0, 16'h7FFF, 16'h0000, 8'd255, 24'h7FFFFF};
    vt[2]  = '{1'b0, 16'h8000, 16'h0000, 8'd255, 24'h800000};
    vt[3]  = '{1'b0, 16'h2000, 16'h1000, 8'd0,   24'h001000};
    vt[4]  = '{1'b0, 16'hE000, 16'h0000, 8'd1,   24'hFEE000};
    vt[5]  = '{1'b0, 16'h0001, 16'hFFFF, 8'd255, 24'h0008F6};
    vt[6]  = '{1'b0, 16'h7FFF, 16'h0000, 8'd28,  24'h7DFF04};
    vt[7]  = '{1'b0, 16'h7FFF, 16'h0000, 8'd29,  24'h7FFFFF};
    vt[8]  = '{1'b0, 16'h7FFF, 16'h7FFF, 8'd28,  24'h7E7F03};
    vt[9]  = '{1'b0, 16'h8000, 16'h0000, 8'd28,  24'h820000};
    vt[10] = '{1'b0, 16'h8000, 16'h0000, 8'd29,  24'h800000};
    vt[11] = '{1'b1, 16'h8000, 16'h0000, 8'd255, 24'h000000};
    vt[12] = '{1'b1, 16'h2000, 16'h0000, 8'd10,  24'h0B4000};
    vt[13] = '{1'b1, 16'h2000, 16'hFFFF, 8'd0,   24'h000000};
    vt[14] = '{1'b1, 16'hE000, 16'h0000, 8'd1,   24'h000000};
    vt[15] = '{1'b1, 16'h0001, 16'hFFFF, 8'd255, 24'h0008F6};

    rst = 1'b1; pix = '0; wdata = '0;
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0; we1 = 1'b0; we2 = 1'b0; wa1 = '0; wa2 = '0;
    tick(); tick();
    check("rst_d1", d1, 24'h0); check("rst_v1", ov1, 1'b0);
    check("rst_d2", d2, 24'h0); check("rst_v2", ov2, 1'b0);
    check("rst_d3", d3, 24'h0); check("rst_v3", ov3, 1'b0);
    rst = 1'b0;
    tick();

    // Single-channel table: latency, pulse width, value and hold.
    for (int i = 0; i < 16; i++) begin
      load1(vt[i].c, vt[i].b);
      pix = {9{vt[i].p}};
      if (vt[i].dsel) v3 = 1'b1; else v1 = 1'b1;
      tick();
      v1 = 1'b0; v3 = 1'b0;
      tick(); tick();
      sel_v = vt[i].dsel ? ov3 : ov1;
      check($sformatf("vec%0d_early", i), sel_v, 1'b0);
      tick();
      sel_v = vt[i].dsel ? ov3 : ov1;
      sel_d = vt[i].dsel ? d3 : d1;
      check($sformatf("vec%0d_valid", i), sel_v, 1'b1);
      check($sformatf("vec%0d_data", i), sel_d, vt[i].e);
      tick();
      sel_v = vt[i].dsel ? ov3 : ov1;
      sel_d = vt[i].dsel ? d3 : d1;
      check($sformatf("vec%0d_pulse_end", i), sel_v, 1'b0);
      check($sformatf("vec%0d_hold", i), sel_d, vt[i].e);
    end

    // Two channels: pulse only after the ch1 window.
    for (int a = 0; a < 19; a++) c2[a] = 16'h2000;
    load2();
    q2.delete();
    pix = {9{8'd1}}; v2 = 1'b1;
    tick();
    pix = {9{8'd2}};
    tick();
    v2 = 1'b0;
    tick(); tick();
    check("two_ch_no_pulse_ch0", ov2, 1'b0);
    tick();
    check("two_ch_valid", ov2, 1'b1);
    check("two_ch_data", d2, 24'h038000);
    tick(); tick(); tick();
    check("two_ch_count", q2.size(), 32'd1);

    // Two channels, distinct coefficients, random pixels and idle gaps.
    for (int a = 0; a < 18; a++) c2[a] = 16'(a*911 - 8000);
    c2[18] = 16'hF000;
    load2();
    q2.delete(); expq.delete(); partial = 0;
    for (int i = 0; i < 100; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      pix = rnd[71:0];
      v2 = 1'b1;
      tick();
      if (i % 2 == 0) partial = dot(0, pix);
      else expq.push_back(sat24(partial + dot(1, pix) + longint'(c2[18])));
      v2 = 1'b0;
      rnd = {$urandom, $urandom, $urandom};
      pix = rnd[71:0];
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end
    repeat (6) tick();
    check("rand_count", q2.size(), 32'd50);
    for (int i = 0; i < expq.size(); i++) check($sformatf("rand_out%0d", i), qat(2, i), expq[i]);

    // Reset between a ch0 and ch1 window, then a fresh pair.
    q2.delete();
    rnd = {$urandom, $urandom, $urandom};
    pix = rnd[71:0]; v2 = 1'b1;
    tick();
    v2 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_d1", d1, 24'h0);
    check("mid_rst_d2", d2, 24'h0);
    check("mid_rst_d3", d3, 24'h0);
    load2();
    rnd = {$urandom, $urandom, $urandom};
    pix = rnd[71:0]; v2 = 1'b1;
    tick();
    partial = dot(0, pix);
    rnd = {$urandom, $urandom, $urandom};
    pix = rnd[71:0];
    tick();
    e = sat24(partial + dot(1, pix) + longint'(c2[18]));
    v2 = 1'b0;
    repeat (6) tick();
    check("post_rst_count", q2.size(), 32'd1);
    check("post_rst_data", qat(2, 0), e);

    // Coefficient write coinciding with a window.
    load1(16'h2000, 16'h0000);
    q1.delete();
    pv = {9{8'd1}};
    pv[39:32] = 8'd10;
    pix = pv;
    we1 = 1'b1; wa1 = 4'd4; wdata = 16'h4000; v1 = 1'b1;
    tick();
    we1 = 1'b0;
    tick();
    v1 = 1'b0;
    repeat (5) tick();
    check("coll_count", q1.size(), 32'd2);
    check("coll_old", qat(1, 0), 24'h024000);
    check("coll_new", qat(1, 1), 24'h038000);
    wr1(10, 16'h7FFF);
    q1.delete();
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    repeat (5) tick();
    check("oor_count", q1.size(), 32'd1);
    check("oor_data", qat(1, 0), 24'h038000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
